cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
Master end of the common data bus (CDB). Collects completed results from the functional units and buffers them per FU. Arbitrates them round-robin onto CDB_LANES broadcast lanes, which are consumed by the reservation stations, physical register file, register status table and ROB. Sits between the FU outputs and every CDB consumer, and owns CDB back-pressure via cdb_ready.

Parameters:
NUM_FU, 4, number of functional-unit result sources
CDB_LANES, 2, results broadcast per cycle (1..NUM_FU)
FIFO_DEPTH, 2, result buffer entries per FU (power of 2, >=2)
PHYS_REG_W, `PHYSICAL_REG_NUM_WIDTH, physical register address width
REG_VAL_W, `REG_VAL_WIDTH, result value width
ROB_TAG_W, `ROB_SIZE_WIDTH, ROB tag width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high
flush  in  1  synchronous squash of all buffered and registered results
fu_valid  in  NUM_FU  FU i presents a result
fu_ready  out  NUM_FU  FU i result accepted this cycle if fu_valid[i]
fu_dst_reg_addr  in  NUM_FU x PHYS_REG_W  destination physical register
fu_result_val  in  NUM_FU x REG_VAL_W  result value
fu_rob_tag  in  NUM_FU x ROB_TAG_W  ROB tag of completing instruction
fu_reg_write  in  NUM_FU  1 = result writes a register (0 for store/branch)
cdb_valid  out  CDB_LANES  lane k carries a result
cdb_register_addr  out  CDB_LANES x PHYS_REG_W
cdb_register_val  out  CDB_LANES x REG_VAL_W
cdb_rob_tag  out  CDB_LANES x ROB_TAG_W
cdb_reg_write  out  CDB_LANES  consumers update reg/RS operands only when 1
cdb_ready  in  1  AND of all consumers' ready; 0 stalls the bus

Behaviour:
- Reset (async): all FIFOs empty, rr_ptr=0, all cdb_* outputs 0. fu_ready=0 while reset is high.
- Per-FU FIFO, written when fu_valid[i] && fu_ready[i]. fu_ready[i] = !full[i] && !flush && !reset.
  - Full is decided from the current count only; there is no pop-through. A full FIFO refuses a push even in a cycle where it pops.
- Grant, computed each cycle from FIFO heads only:
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first min(CDB_LANES, #non-empty) non-empty FUs are granted in scan order; the j-th granted FU maps to lane j.
  - Unused lanes are invalid.
- Output register update:
  - If cdb_ready=1: granted heads are popped and loaded into the lane registers; cdb_valid[k]=1 for filled lanes, 0 otherwise.
  - rr_ptr <= (last granted index + 1) mod NUM_FU; unchanged if nothing was granted.
  - If cdb_ready=0: no pops, lane registers and rr_ptr hold. Outputs stay stable; consumers see the same broadcast until cdb_ready=1.
- Latency: a result accepted at edge N is visible on the CDB after edge N+1 at the earliest (1 cycle, no bypass).
- Per-FU ordering is preserved (FIFO). Only one entry per FU is popped per cycle, so one FU never occupies two lanes in the same cycle.
- Flush (sync, priority over push/pop):
  - All FIFOs emptied; cdb_valid <= 0; rr_ptr <= 0.
  - Results presented during the flush cycle are dropped, since fu_ready=0.
- Counters wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1. Overflow and underflow are impossible by construction; assertions check both.
- Lane output fields for invalid lanes are don't-care and are held at 0.

Decomposition:
- Shared package (next to control_t / reservation_station_t): typedef cdb_entry_t {dst_reg_addr, result_val, rob_tag, reg_write}. Width constants come from the existing `defines.
- One natural sub-module: cdb_fu_fifo (per-FU synchronous FIFO of cdb_entry_t with push/pop/flush, full/empty, count), instantiated NUM_FU times.
- Round-robin multi-grant logic stays inline as a function.

Test Plan:
1. Single result: FU0 pushes addr=5, val=0xDEADBEEF, tag=3, reg_write=1 at edge 1, cdb_ready=1 -> after edge 2, cdb_valid=2'b01 and lane0 = {5, 0xDEADBEEF, 3, 1}; after edge 3, cdb_valid=0.
2. Burst, NUM_FU=4, CDB_LANES=2: all FUs push at edge 1, rr_ptr=0 -> edge 2 lanes = FU0, FU1 (rr_ptr=2); edge 3 lanes = FU2, FU3 (rr_ptr=0); edge 4 cdb_valid=0.
3. Back-pressure: cdb_ready=0 for 4 cycles while FU1 pushes vals 10, 11, 12 on consecutive cycles -> fu_ready[1]=0 after two accepts and 12 is held by the FU; CDB outputs stable. Release -> 10, 11, 12 broadcast in order on successive cycles.
4. Fairness, CDB_LANES=1: FU0 and FU3 continuously valid -> grants alternate FU0, FU3, FU0, ...; neither starves over 20 cycles.
5. Flush: FIFOs hold 3 entries and lane0 is valid; assert flush for 1 cycle -> fu_ready=0 that cycle, cdb_valid=0 next edge; no pre-flush result ever appears afterwards.
6. Async reset asserted mid-cycle while cdb_valid=2'b11 -> cdb_valid=0 immediately, before the next edge. After release, the first push appears 1 cycle later on lane0.

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and width constants for the common data bus (CDB) broadcaster.
//
// Contents:
//   PKG_PHYS_REG_W, PKG_REG_VAL_W, PKG_ROB_TAG_W : widths taken from the core defines
//   cdb_entry_t : one completed result as buffered and broadcast on a CDB lane
//
// The core normally supplies the width defines. The fallbacks below only apply when
// this package is compiled on its own.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package cdb_broadcaster_pkg;

    localparam int PKG_PHYS_REG_W = `PHYSICAL_REG_NUM_WIDTH;
    localparam int PKG_REG_VAL_W  = `REG_VAL_WIDTH;
    localparam int PKG_ROB_TAG_W  = `ROB_SIZE_WIDTH;

    typedef struct packed {
        logic [PKG_PHYS_REG_W-1:0] dst_reg_addr;
        logic [PKG_REG_VAL_W-1:0]  result_val;
        logic [PKG_ROB_TAG_W-1:0]  rob_tag;
        logic                      reg_write;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-functional-unit result FIFO feeding the CDB arbiter.
//
// Ports:
//   clk, reset (async, active-high)
//   flush     : synchronous clear of all entries; it overrides push and pop
//   push, din : write one entry (the caller guarantees !full)
//   pop       : drop the head entry (the caller guarantees !empty)
//   dout      : head entry, valid when !empty
//   full, empty, count : occupancy, decided from the registered count only
module cdb_fu_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  cdb_entry_t       din,
    output cdb_entry_t       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    cdb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && full && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty && !flush));

endmodule

// File: rtl/cdb_broadcaster.sv
// Master end of the common data bus. Buffers completed FU results per FU and
// broadcasts up to CDB_LANES of them per cycle, chosen round-robin.
//
// Ports:
//   clk, reset (async, active-high), flush (sync squash)
//   fu_valid / fu_ready           : per-FU result handshake
//   fu_dst_reg_addr, fu_result_val, fu_rob_tag, fu_reg_write : per-FU result fields
//   cdb_valid, cdb_register_addr, cdb_register_val, cdb_rob_tag, cdb_reg_write :
//                                   registered broadcast lanes (zero when a lane is invalid)
//   cdb_ready                     : consumers can take a broadcast; 0 holds the lanes
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int CDB_LANES  = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int PHYS_REG_W = PKG_PHYS_REG_W,
    parameter int REG_VAL_W  = PKG_REG_VAL_W,
    parameter int ROB_TAG_W  = PKG_ROB_TAG_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic [NUM_FU-1:0]                    fu_valid,
    output logic [NUM_FU-1:0]                    fu_ready,
    input  logic [NUM_FU-1:0][PHYS_REG_W-1:0]    fu_dst_reg_addr,
    input  logic [NUM_FU-1:0][REG_VAL_W-1:0]     fu_result_val,
    input  logic [NUM_FU-1:0][ROB_TAG_W-1:0]     fu_rob_tag,
    input  logic [NUM_FU-1:0]                    fu_reg_write,
    output logic [CDB_LANES-1:0]                 cdb_valid,
    output logic [CDB_LANES-1:0][PHYS_REG_W-1:0] cdb_register_addr,
    output logic [CDB_LANES-1:0][REG_VAL_W-1:0]  cdb_register_val,
    output logic [CDB_LANES-1:0][ROB_TAG_W-1:0]  cdb_rob_tag,
    output logic [CDB_LANES-1:0]                 cdb_reg_write,
    input  logic                                 cdb_ready
);

    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CDB_LANES-1:0]            vld;
        logic [CDB_LANES-1:0][IDX_W-1:0] idx;
        logic [NUM_FU-1:0]               pop;
        logic [IDX_W-1:0]                next_ptr;
    } grant_t;

    // Walk FUs starting at ptr; the j-th non-empty one found takes lane j until lanes
    // run out. The pointer moves just past the last FU granted.
    function automatic grant_t rr_grant(input logic [NUM_FU-1:0] nonempty,
                                        input logic [IDX_W-1:0]  ptr);
        grant_t g;
        int     lane;
        int     fu;
        g          = '0;
        g.next_ptr = ptr;
        lane       = 0;
        for (int s = 0; s < NUM_FU; s++) begin
            fu = (int'(ptr) + s) % NUM_FU;
            if (nonempty[fu] && (lane < CDB_LANES)) begin
                g.vld[lane] = 1'b1;
                g.idx[lane] = IDX_W'(fu);
                g.pop[fu]   = 1'b1;
                g.next_ptr  = IDX_W'((fu + 1) % NUM_FU);
                lane        = lane + 1;
            end
        end
        return g;
    endfunction

    cdb_entry_t                        fu_entry [NUM_FU];
    cdb_entry_t                        head     [NUM_FU];
    logic [NUM_FU-1:0]                 full;
    logic [NUM_FU-1:0]                 empty;
    logic [NUM_FU-1:0]                 push;
    logic [NUM_FU-1:0]                 pop;
    logic [CNT_W-1:0]                  fifo_count [NUM_FU];
    grant_t                            g;

    logic [CDB_LANES-1:0]              vld_q, vld_d;
    cdb_entry_t [CDB_LANES-1:0]        lane_q, lane_d;
    logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_entry[i] = '{dst_reg_addr: fu_dst_reg_addr[i],
                               result_val:   fu_result_val[i],
                               rob_tag:      fu_rob_tag[i],
                               reg_write:    fu_reg_write[i]};
        // No pop-through: a full FIFO refuses even while its head is leaving.
        assign fu_ready[i] = !full[i] && !flush && !reset;
        assign push[i]     = fu_valid[i] && fu_ready[i];

        cdb_fu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (fu_entry[i]),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (fifo_count[i])
        );

        a_count_range: assert property (@(posedge clk) disable iff (reset)
                                        fifo_count[i] <= CNT_W'(FIFO_DEPTH));
    end

    always_comb begin
        g        = rr_grant(~empty, rr_ptr_q);
        vld_d    = vld_q;
        lane_d   = lane_q;
        rr_ptr_d = rr_ptr_q;
        pop      = '0;
        if (flush) begin
            vld_d    = '0;
            lane_d   = '0;
            rr_ptr_d = '0;
        end else if (cdb_ready) begin
            vld_d    = g.vld;
            rr_ptr_d = g.next_ptr;
            pop      = g.pop;
            for (int k = 0; k < CDB_LANES; k++) begin
                lane_d[k] = g.vld[k] ? head[g.idx[k]] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            lane_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            lane_q   <= lane_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        cdb_valid = vld_q;
        for (int k = 0; k < CDB_LANES; k++) begin
            cdb_register_addr[k] = lane_q[k].dst_reg_addr;
            cdb_register_val[k]  = lane_q[k].result_val;
            cdb_rob_tag[k]       = lane_q[k].rob_tag;
            cdb_reg_write[k]     = lane_q[k].reg_write;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
`timescale 1ns/1ps
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    localparam int NUM_FU     = 4;
    localparam int CDB_LANES  = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int AW = PKG_PHYS_REG_W;
    localparam int VW = PKG_REG_VAL_W;
    localparam int TW = PKG_ROB_TAG_W;

    logic clk = 1'b0;
    logic reset, flush, cdb_ready;
    logic [NUM_FU-1:0]                 fu_valid, fu_ready, fu_reg_write;
    logic [NUM_FU-1:0][AW-1:0]         fu_dst_reg_addr;
    logic [NUM_FU-1:0][VW-1:0]         fu_result_val;
    logic [NUM_FU-1:0][TW-1:0]         fu_rob_tag;
    logic [CDB_LANES-1:0]              cdb_valid, cdb_reg_write;
    logic [CDB_LANES-1:0][AW-1:0]      cdb_register_addr;
    logic [CDB_LANES-1:0][VW-1:0]      cdb_register_val;
    logic [CDB_LANES-1:0][TW-1:0]      cdb_rob_tag;

    always #5 clk = ~clk;

    cdb_broadcaster #(.NUM_FU(NUM_FU), .CDB_LANES(CDB_LANES), .FIFO_DEPTH(FIFO_DEPTH),
                      .PHYS_REG_W(AW), .REG_VAL_W(VW), .ROB_TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_dst_reg_addr(fu_dst_reg_addr), .fu_result_val(fu_result_val),
        .fu_rob_tag(fu_rob_tag), .fu_reg_write(fu_reg_write),
        .cdb_valid(cdb_valid), .cdb_register_addr(cdb_register_addr),
        .cdb_register_val(cdb_register_val), .cdb_rob_tag(cdb_rob_tag),
        .cdb_reg_write(cdb_reg_write), .cdb_ready(cdb_ready)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [VW-1:0] v;
        logic [TW-1:0] t;
        logic          w;
    } ent_t;

    // Reference model: one queue per FU, a round-robin start index, expected lanes.
    ent_t                 mq [NUM_FU][$];
    int                   rr;
    logic [CDB_LANES-1:0] exp_vld;
    ent_t                 exp_lane [CDB_LANES];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        rr      = 0;
        exp_vld = '0;
        for (int k = 0; k < CDB_LANES; k++) exp_lane[k] = '0;
    endtask

    // One rising edge of the intended behaviour, using the inputs held across it.
    task automatic model_step();
        bit acc [NUM_FU];
        int used;
        int fu;
        int last;
        if (reset) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NUM_FU; i++)
            acc[i] = fu_valid[i] && (mq[i].size() < FIFO_DEPTH) && !flush;
        if (flush) begin
            model_clear();
            return;
        end
        if (cdb_ready) begin
            exp_vld = '0;
            for (int k = 0; k < CDB_LANES; k++) exp_lane[k] = '0;
            used = 0;
            last = -1;
            for (int s = 0; s < NUM_FU; s++) begin
                fu = (rr + s) % NUM_FU;
                if (used < CDB_LANES && mq[fu].size() > 0) begin
                    exp_vld[used]  = 1'b1;
                    exp_lane[used] = mq[fu].pop_front();
                    used++;
                    last = fu;
                end
            end
            if (last >= 0) rr = (last + 1) % NUM_FU;
        end
        for (int i = 0; i < NUM_FU; i++)
            if (acc[i]) mq[i].push_back('{fu_dst_reg_addr[i], fu_result_val[i],
                                           fu_rob_tag[i], fu_reg_write[i]});
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [NUM_FU-1:0] er;
        ent_t              obs;
        #1;
        for (int i = 0; i < NUM_FU; i++)
            er[i] = (mq[i].size() < FIFO_DEPTH) && !flush && !reset;
        chk("fu_ready", 64'(fu_ready), 64'(er));
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cdb_valid", 64'(cdb_valid), 64'(exp_vld));
        for (int k = 0; k < CDB_LANES; k++) begin
            obs = '{cdb_register_addr[k], cdb_register_val[k], cdb_rob_tag[k], cdb_reg_write[k]};
            chk($sformatf("lane%0d", k), 64'(obs), 64'(exp_lane[k]));
        end
    endtask

    task automatic set_fu(input int i, input logic [AW-1:0] a, input logic [VW-1:0] v,
                          input logic [TW-1:0] t, input logic w);
        fu_dst_reg_addr[i] = a;
        fu_result_val[i]   = v;
        fu_rob_tag[i]      = t;
        fu_reg_write[i]    = w;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NUM_FU; i++)
            set_fu(i, AW'($urandom), VW'($urandom), TW'($urandom), 1'($urandom));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int cnt0, cnt3;

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_ready = 1'b1; fu_valid = '0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, '0, '0, '0, 1'b0);
        model_clear();
        @(negedge clk);
        repeat (2) cycle();
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        reset = 1'b0;

        // Single result from FU0.
        set_fu(0, AW'(5), 32'hDEADBEEF, TW'(3), 1'b1);
        fu_valid = 4'b0001;
        cycle();
        fu_valid = '0;
        cycle();
        chk("t1_vld",  64'(cdb_valid), 64'b01);
        chk("t1_addr", 64'(cdb_register_addr[0]), 64'd5);
        chk("t1_val",  64'(cdb_register_val[0]), 64'hDEADBEEF);
        chk("t1_tag",  64'(cdb_rob_tag[0]), 64'd3);
        chk("t1_rw",   64'(cdb_reg_write[0]), 64'd1);
        cycle();
        chk("t1_idle", 64'(cdb_valid), 64'd0);

        // Burst from every FU with the pointer back at 0.
        do_flush();
        for (int i = 0; i < NUM_FU; i++) set_fu(i, AW'(i), VW'(100 + i), TW'(i), 1'b1);
        fu_valid = '1;
        cycle();
        fu_valid = '0;
        cycle();
        chk("t2_tags_a", 64'({cdb_rob_tag[1], cdb_rob_tag[0]}), 64'({TW'(1), TW'(0)}));
        cycle();
        chk("t2_tags_b", 64'({cdb_rob_tag[1], cdb_rob_tag[0]}), 64'({TW'(3), TW'(2)}));
        cycle();
        chk("t2_idle", 64'(cdb_valid), 64'd0);

        // Back-pressure on a single FU.
        do_flush();
        cdb_ready = 1'b0;
        fu_valid  = 4'b0010;
        set_fu(1, AW'(1), VW'(10), TW'(1), 1'b1); cycle();
        set_fu(1, AW'(1), VW'(11), TW'(1), 1'b1); cycle();
        set_fu(1, AW'(1), VW'(12), TW'(1), 1'b1); cycle();
        chk("t3_refuse", 64'(fu_ready[1]), 64'd0);
        cycle();
        chk("t3_stall", 64'(cdb_valid), 64'd0);
        cdb_ready = 1'b1;
        cycle();
        chk("t3_v10", 64'(cdb_register_val[0]), 64'd10);
        cycle();
        chk("t3_v11", 64'(cdb_register_val[0]), 64'd11);
        fu_valid = '0;
        cycle();
        chk("t3_v12", 64'(cdb_register_val[0]), 64'd12);

        // Fairness between two continuously valid FUs.
        do_flush();
        set_fu(0, AW'(0), VW'(0), TW'(0), 1'b1);
        set_fu(3, AW'(3), VW'(3), TW'(3), 1'b1);
        fu_valid = 4'b1001;
        cnt0 = 0; cnt3 = 0;
        repeat (20) begin
            cycle();
            for (int k = 0; k < CDB_LANES; k++) if (cdb_valid[k]) begin
                if (cdb_rob_tag[k] == TW'(0)) cnt0++;
                if (cdb_rob_tag[k] == TW'(3)) cnt3++;
            end
        end
        chk("t4_fu0_served", 64'(cnt0 >= 8), 64'd1);
        chk("t4_fu3_served", 64'(cnt3 >= 8), 64'd1);

        // Flush with buffered and broadcast results in flight.
        do_flush();
        rand_fields();
        fu_valid = '1;
        cycle();
        rand_fields();
        cycle();
        fu_valid  = '0;
        cdb_ready = 1'b0;
        cycle();
        chk("t5_lane0_live", 64'(cdb_valid[0]), 64'd1);
        flush = 1'b1;
        #1 chk("t5_ready_low", 64'(fu_ready), 64'd0);
        cycle();
        flush = 1'b0;
        chk("t5_flushed", 64'(cdb_valid), 64'd0);
        cdb_ready = 1'b1;
        repeat (4) begin
            cycle();
            chk("t5_no_stale", 64'(cdb_valid), 64'd0);
        end

        // Asynchronous reset while both lanes are valid.
        rand_fields();
        fu_valid = '1;
        cycle();
        fu_valid = '0;
        cycle();
        chk("t6_both", 64'(cdb_valid), 64'b11);
        #2 reset = 1'b1;
        #1 chk("t6_async", 64'(cdb_valid), 64'd0);
        model_clear();
        @(negedge clk);
        cycle();
        reset = 1'b0;
        set_fu(2, AW'(9), VW'(77), TW'(7), 1'b0);
        fu_valid = 4'b0100;
        cycle();
        fu_valid = '0;
        cycle();
        chk("t6_lane0", 64'(cdb_valid), 64'b01);
        chk("t6_val", 64'(cdb_register_val[0]), 64'd77);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            cdb_ready = ($urandom_range(0, 3) != 0);
            fu_valid  = NUM_FU'($urandom);
            rand_fields();
            cycle();
        end
        reset = 1'b0; flush = 1'b0; fu_valid = '0; cdb_ready = 1'b1;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
